// File: rtl/task0_adder_if.sv
// Operand and result bundle for the single-bit full adder cell.
// Clock and reset stay as plain ports on the adder itself.
interface task0_adder_if;
    logic i_w_a;
    logic i_w_b;
    logic i_w_cin;
    logic o_w_s;
    logic o_w_cout;

    modport master (
        output i_w_a,
        output i_w_b,
        output i_w_cin,
        input  o_w_s,
        input  o_w_cout
    );

    modport slave (
        input  i_w_a,
        input  i_w_b,
        input  i_w_cin,
        output o_w_s,
        output o_w_cout
    );
endinterface

// File: rtl/task0_adder.sv
// Single-bit full adder built from two half-adder stages, with an optional
// output register (REGISTERED=1) or a purely combinational path (REGISTERED=0).
module task0_adder #(
    parameter bit REGISTERED = 1'b1
) (
    input  logic          i_w_clk,
    input  logic          i_w_rst_n,
    task0_adder_if.slave  bus
);

    // Returns {carry, sum}; plain operators so X/Z on an operand reaches the result.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    logic [1:0] ha1_s;
    logic [1:0] ha2_s;
    logic       s_d;
    logic       cout_d;

    // Core: stage 1 gives propagate/generate, stage 2 folds in the carry-in.
    always_comb begin
        ha1_s  = half_add(bus.i_w_a, bus.i_w_b);
        ha2_s  = half_add(ha1_s[0], bus.i_w_cin);
        s_d    = ha2_s[0];
        cout_d = ha1_s[1] | ha2_s[1];
    end

    generate
        if (REGISTERED) begin : g_reg
            logic s_q;
            logic cout_q;

            // Output register loads every edge; reset clears it without a clock.
            always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
                if (!i_w_rst_n) begin
                    s_q    <= 1'b0;
                    cout_q <= 1'b0;
                end else begin
                    s_q    <= s_d;
                    cout_q <= cout_d;
                end
            end

            assign bus.o_w_s    = s_q;
            assign bus.o_w_cout = cout_q;
        end else begin : g_comb
            // Clock and reset are intentionally ignored in this mode.
            logic unused_clk_rst;
            assign unused_clk_rst = i_w_clk ^ i_w_rst_n;

            assign bus.o_w_s    = s_d;
            assign bus.o_w_cout = cout_d;
        end
    endgenerate

endmodule

// File: tb/tb_task0_adder.sv
// Self-checking bench: registered and bypass instances checked against a
// plain-arithmetic model ({cout,s} = a+b+cin, forced to 0 under reset).
module tb_task0_adder;

    logic clk;
    logic rst_n;
    logic idle_clk;
    logic comb_rst_n;

    int n_vec;
    int n_err;

    task0_adder_if reg_bus ();
    task0_adder_if comb_bus ();

    task0_adder #(.REGISTERED(1'b1)) dut_reg (
        .i_w_clk   (clk),
        .i_w_rst_n (rst_n),
        .bus       (reg_bus.slave)
    );

    task0_adder #(.REGISTERED(1'b0)) dut_comb (
        .i_w_clk   (idle_clk),
        .i_w_rst_n (comb_rst_n),
        .bus       (comb_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] model_sum(input logic a, input logic b, input logic c);
        int total;
        total = int'(a) + int'(b) + int'(c);
        return total[1:0];
    endfunction

    task automatic check_val(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got {cout,s}=%b, expected %b", tag, got, exp);
        end
    endtask

    task automatic drive_reg(input logic [2:0] abc);
        reg_bus.i_w_a   = abc[2];
        reg_bus.i_w_b   = abc[1];
        reg_bus.i_w_cin = abc[0];
    endtask

    logic [1:0] exp_v;
    logic [2:0] abc_v;

    initial begin
        n_vec      = 0;
        n_err      = 0;
        idle_clk   = 1'b0;
        comb_rst_n = 1'b1;
        rst_n      = 1'b0;
        drive_reg(3'b111);
        comb_bus.i_w_a   = 1'b0;
        comb_bus.i_w_b   = 1'b0;
        comb_bus.i_w_cin = 1'b0;

        // Reset held with all-ones inputs and clock running.
        #1;
        check_val("reset_async_t1", {reg_bus.o_w_cout, reg_bus.o_w_s}, 2'b00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val("reset_hold", {reg_bus.o_w_cout, reg_bus.o_w_s}, 2'b00);
        end

        // Release between edges, then exhaustive sweep a-outer, cin-inner.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            abc_v = i[2:0];
            drive_reg(abc_v);
            @(posedge clk);
            #1;
            exp_v = model_sum(abc_v[2], abc_v[1], abc_v[0]);
            check_val("sweep", {reg_bus.o_w_cout, reg_bus.o_w_s}, exp_v);
            @(negedge clk);
        end

        // Inputs changing between edges must not disturb the registered output.
        drive_reg(3'b000);
        @(posedge clk);
        #1;
        drive_reg(3'b111);
        #2;
        check_val("between_edges", {reg_bus.o_w_cout, reg_bus.o_w_s}, 2'b00);

        // Hold 110 for 5 cycles.
        @(negedge clk);
        drive_reg(3'b110);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_val("hold_110", {reg_bus.o_w_cout, reg_bus.o_w_s}, 2'b10);
        end

        // Async reset mid-stream while showing 11.
        @(negedge clk);
        drive_reg(3'b111);
        @(posedge clk);
        #1;
        check_val("pre_reset_111", {reg_bus.o_w_cout, reg_bus.o_w_s}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midstream_async_clr", {reg_bus.o_w_cout, reg_bus.o_w_s}, 2'b00);
        @(posedge clk);
        #1;
        check_val("midstream_hold_clr", {reg_bus.o_w_cout, reg_bus.o_w_s}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("release_no_load", {reg_bus.o_w_cout, reg_bus.o_w_s}, 2'b00);
        @(posedge clk);
        #1;
        check_val("restore_111", {reg_bus.o_w_cout, reg_bus.o_w_s}, 2'b11);

        // Randomized stream with occasional mid-cycle reset pulses.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            abc_v = 3'($urandom_range(7, 0));
            drive_reg(abc_v);
            if ($urandom_range(15, 0) == 0) begin
                rst_n = 1'b0;
                #1;
                check_val("rand_async_clr", {reg_bus.o_w_cout, reg_bus.o_w_s}, 2'b00);
                @(posedge clk);
                #1;
                check_val("rand_reset_hold", {reg_bus.o_w_cout, reg_bus.o_w_s}, 2'b00);
                #2;
                rst_n = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                exp_v = model_sum(abc_v[2], abc_v[1], abc_v[0]);
                check_val("rand_reg", {reg_bus.o_w_cout, reg_bus.o_w_s}, exp_v);
            end
        end

        // Bypass instance: 10 ns steps, no clock, reset toggling ignored.
        for (int i = 0; i < 8; i++) begin
            abc_v = i[2:0];
            comb_bus.i_w_a   = abc_v[2];
            comb_bus.i_w_b   = abc_v[1];
            comb_bus.i_w_cin = abc_v[0];
            #1;
            exp_v = model_sum(abc_v[2], abc_v[1], abc_v[0]);
            check_val("bypass_sweep", {comb_bus.o_w_cout, comb_bus.o_w_s}, exp_v);
            comb_rst_n = 1'b0;
            #1;
            check_val("bypass_rst_low", {comb_bus.o_w_cout, comb_bus.o_w_s}, exp_v);
            comb_rst_n = 1'b1;
            #8;
        end
        for (int i = 0; i < 50; i++) begin
            abc_v = 3'($urandom_range(7, 0));
            comb_bus.i_w_a   = abc_v[2];
            comb_bus.i_w_b   = abc_v[1];
            comb_bus.i_w_cin = abc_v[0];
            comb_rst_n = 1'($urandom_range(1, 0));
            #1;
            exp_v = model_sum(abc_v[2], abc_v[1], abc_v[0]);
            check_val("bypass_rand", {comb_bus.o_w_cout, comb_bus.o_w_s}, exp_v);
            #9;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
